scm_ctrl: RTL

SCM_CTRL -- requirements
Module: scm_ctrl

---
 rtl/scm_pkg.sv | 23 ++
 rtl/scm_rr_arb.sv | 65 ++++++
 rtl/scm_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/scm_pkg.sv
// Shared types and sizing helpers for the LUT-loading SCM controller.
package scm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_READY = 2'd3
  } scm_state_e;

  localparam int unsigned DefaultC = 32;
  localparam int unsigned DefaultK = 16;

  function automatic int unsigned scm_depth(input int unsigned c, input int unsigned k);
    return c * k;
  endfunction

  // Never return a zero width, even for a single-entry table.
  function automatic int unsigned scm_addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/scm_rr_arb.sv
// Round-robin arbiter: one-hot grant, priority starts just after the last winner.
module scm_rr_arb import scm_pkg::*; #(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic         gnt_any_o
);

  localparam int unsigned IdxW = scm_addr_width(N);

  logic [IdxW-1:0] ptr_q, ptr_d, win_s;
  logic [IdxW:0]   cand_s;
  logic [N-1:0]    gnt_s;
  logic            found_s;

  // Scan requesters starting at the pointer, wrapping modulo N.
  always_comb begin
    gnt_s   = '0;
    win_s   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int i = 0; i < N; i++) begin
      cand_s = {1'b0, ptr_q} + (IdxW+1)'(i);
      if (cand_s >= (IdxW+1)'(N)) begin
        cand_s = cand_s - (IdxW+1)'(N);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && req_i[cand_s[IdxW-1:0]]) begin
        found_s                  = 1'b1;
        win_s                    = cand_s[IdxW-1:0];
        gnt_s[cand_s[IdxW-1:0]] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer moves to the requester after the winner.
  always_comb begin
    if (!found_s) begin
      ptr_d = ptr_q;
    end else if (win_s == IdxW'(N-1)) begin
      ptr_d = '0;
    end else begin
      ptr_d = win_s + IdxW'(1);
    end
  end

  // Pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o     = gnt_s;
  assign gnt_any_o = found_s;

endmodule

// File: rtl/scm_ctrl.sv
// SCM controller: streams a full LUT into an external SCM, then serves
// round-robin single-cycle reads to several requesters.
module scm_ctrl import scm_pkg::*; #(
  parameter int unsigned C              = DefaultC,
  parameter int unsigned K              = DefaultK,
  parameter int unsigned DataTypeWidth  = 16,
  parameter int unsigned NumReaders     = 4,
  parameter int unsigned TotalAddrWidth = scm_addr_width(scm_depth(C, K))
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 load_start_i,
  input  logic                                 lut_valid_i,
  output logic                                 lut_ready_o,
  input  logic [DataTypeWidth-1:0]             lut_data_i,
  output logic                                 load_busy_o,
  output logic                                 load_done_o,
  output logic                                 table_valid_o,
  input  logic [NumReaders-1:0]                rd_req_i,
  input  logic [NumReaders*TotalAddrWidth-1:0] rd_addr_i,
  output logic [NumReaders-1:0]                rd_gnt_o,
  output logic [NumReaders-1:0]                rd_valid_o,
  output logic [DataTypeWidth-1:0]             rd_data_o,
  output logic [TotalAddrWidth-1:0]            raddr_o,
  input  logic [DataTypeWidth-1:0]             rdata_i,
  output logic [TotalAddrWidth-1:0]            waddr_o,
  output logic [DataTypeWidth-1:0]             wdata_o,
  output logic                                 we_o
);

  localparam int unsigned Depth = scm_depth(C, K);
  localparam logic [TotalAddrWidth-1:0] LastAddr = TotalAddrWidth'(Depth - 1);

  scm_state_e                state_q, state_d;
  logic [TotalAddrWidth-1:0] wcnt_q, wcnt_d;
  logic                      xfer_s;
  logic                      arb_en_s;
  logic                      drain_q;
  logic [NumReaders-1:0]     gnt_s;
  logic                      gnt_any_s;
  logic [TotalAddrWidth-1:0] sel_addr_s;
  logic [TotalAddrWidth-1:0] raddr_q;
  logic [NumReaders-1:0]     rd_valid_q;
  logic [DataTypeWidth-1:0]  rd_data_q;

  // FSM state and write-counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  // Next-state logic; the counter parks on the last address rather than wrapping.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      ST_IDLE, ST_READY: begin
        if (load_start_i) begin
          state_d = ST_LOAD;
          wcnt_d  = '0;
        end else begin
          state_d = state_q;
        end
      end
      ST_LOAD: begin
        if (xfer_s && (wcnt_q == LastAddr)) begin
          state_d = ST_DRAIN;
        end else if (xfer_s) begin
          wcnt_d = wcnt_q + TotalAddrWidth'(1);
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_DRAIN: state_d = ST_READY;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM-decoded outputs and the combinational write port.
  always_comb begin
    lut_ready_o   = (state_q == ST_LOAD);
    xfer_s        = lut_ready_o & lut_valid_i;
    we_o          = xfer_s;
    waddr_o       = xfer_s ? wcnt_q : '0;
    wdata_o       = xfer_s ? lut_data_i : '0;
    load_busy_o   = (state_q == ST_LOAD) || (state_q == ST_DRAIN);
    table_valid_o = (state_q == ST_READY);
    load_done_o   = (state_q == ST_READY) && drain_q;
    arb_en_s      = (state_q == ST_READY);
  end

  scm_rr_arb #(
    .N (NumReaders)
  ) u_arb (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .req_i     (rd_req_i & {NumReaders{arb_en_s}}),
    .gnt_o     (gnt_s),
    .gnt_any_o (gnt_any_s)
  );

  // Select the granted requester's address; raddr_o holds between grants.
  always_comb begin
    sel_addr_s = '0;
    for (int i = 0; i < NumReaders; i++) begin
      if (gnt_s[i]) begin
        sel_addr_s = rd_addr_i[i*TotalAddrWidth +: TotalAddrWidth];
      end else begin
        sel_addr_s = sel_addr_s;
      end
    end
    raddr_o = gnt_any_s ? sel_addr_s : raddr_q;
  end

  // Read-side registers: data captured at the grant edge, valid tagged next cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      drain_q    <= 1'b0;
      raddr_q    <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      drain_q    <= (state_q == ST_DRAIN);
      rd_valid_q <= gnt_s;
      if (gnt_any_s) begin
        raddr_q   <= sel_addr_s;
        rd_data_q <= rdata_i;
      end else begin
        raddr_q   <= raddr_q;
        rd_data_q <= rd_data_q;
      end
    end
  end

  assign rd_gnt_o   = gnt_s;
  assign rd_valid_o = rd_valid_q;
  assign rd_data_o  = rd_data_q;

endmodule
